// File: rtl/sc_pkg.sv
// ----------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the stochastic-number-generator front end.
//   fsm_state_t : controller state (IDLE, RUN, DONE)
//   lfsr_taps() : feedback tap mask for a maximal-length Fibonacci LFSR of
//                 width n (4..16); bit k-1 set means stage k is tapped.
// ----------------------------------------------------------------------------
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Primitive-polynomial tap masks. Every entry gives a period of 2^n-1
    // over all non-zero states.
    function automatic logic [15:0] lfsr_taps(input int n);
        logic [15:0] mask;
        case (n)
            4:       mask = 16'h000C;
            5:       mask = 16'h0014;
            6:       mask = 16'h0030;
            7:       mask = 16'h0060;
            8:       mask = 16'h00B8;
            9:       mask = 16'h0110;
            10:      mask = 16'h0240;
            11:      mask = 16'h0500;
            12:      mask = 16'h0829;
            13:      mask = 16'h100D;
            14:      mask = 16'h2015;
            15:      mask = 16'h6000;
            16:      mask = 16'hD008;
            default: mask = 16'h00B8;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// ----------------------------------------------------------------------------
// lfsr_gen
// Maximal-length Fibonacci LFSR with synchronous load.
//   clk, rst : clock and asynchronous active-high reset (state returns to 1)
//   load     : capture seed; a zero seed is replaced by 1 so the register
//              never enters the all-zero lock-up state
//   enable   : advance one step
//   seed     : N-bit seed value
//   state    : current LFSR contents
// ----------------------------------------------------------------------------
module lfsr_gen
    import sc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         enable,
    input  logic [N-1:0] seed,
    output logic [N-1:0] state
);

    localparam logic [15:0]  TAP_ALL = lfsr_taps(N);
    localparam logic [N-1:0] TAPS    = TAP_ALL[N-1:0];

    logic fb;

    assign fb = ^(state & TAPS);

    // Load takes priority so a new run always starts from its own seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= N'(1);
        end else if (load) begin
            state <= (seed == '0) ? N'(1) : seed;
        end else if (enable) begin
            state <= {state[N-2:0], fb};
        end
    end

endmodule

// File: rtl/sng_et_ctrl.sv
// ----------------------------------------------------------------------------
// sng_et_ctrl
// Drives a variable-shift bitstream counter: encodes x as a stochastic
// bitstream Z (LFSR vs. comparator) for up to 2^len_log2 cycles, issues
// periodic rshift pulses, and stops early on et_stop.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : run request, accepted only in IDLE
//   x            : value to encode (latched on accepted start)
//   seed         : LFSR seed (latched; 0 behaves as 1)
//   len_log2     : log2 of run length, clamped to N
//   shift_period : cycles between rshift pulses, 0 disables
//   et_stop      : early termination, honoured only in RUN
//   busy         : high in RUN and DONE
//   z_valid      : high while Z is meaningful (RUN)
//   Z            : stochastic bit, 0 when z_valid is low
//   rshift       : one-cycle pulse while z_valid is high
//   done         : one-cycle pulse after the last valid Z
// ----------------------------------------------------------------------------
module sng_et_ctrl
    import sc_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 8,
    localparam int LW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  x,
    input  logic [N-1:0]  seed,
    input  logic [LW-1:0] len_log2,
    input  logic [N-1:0]  shift_period,
    input  logic          et_stop,
    output logic          busy,
    output logic          z_valid,
    output logic          Z,
    output logic          rshift,
    output logic          done
);

    fsm_state_t    state;
    logic [W-1:0]  x_q;
    logic [LW-1:0] len_q;
    logic [N-1:0]  period_q;
    logic [N-1:0]  phase;
    logic [N:0]    cnt;
    logic [N:0]    last_cnt;
    logic [N-1:0]  lfsr;
    logic [LW-1:0] len_clamped;
    logic          load;
    logic          last;

    assign len_clamped = (len_log2 > LW'(N)) ? LW'(N) : len_log2;
    assign load        = (state == IDLE) && start;
    assign last_cnt    = ((N + 1)'(1) << len_q) - (N + 1)'(1);
    assign last        = (cnt == last_cnt);

    lfsr_gen #(.N(N)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .enable (z_valid),
        .seed   (seed),
        .state  (lfsr)
    );

    // phase tracks cnt modulo the shift period, so phase == period-1 is the
    // same as (cnt+1) being a multiple of the period without a divider.
    assign Z      = z_valid && (lfsr[N-1 -: W] < x_q);
    assign rshift = z_valid && (period_q != '0) && (phase == period_q - N'(1))
                    && !last && !et_stop;

    // Controller: busy/z_valid/done are registered alongside the state so
    // they are glitch-free decodes of where the run currently is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            x_q      <= '0;
            len_q    <= '0;
            period_q <= '0;
            phase    <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            z_valid  <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_q      <= x;
                        len_q    <= len_clamped;
                        period_q <= shift_period;
                        phase    <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        z_valid  <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    cnt   <= cnt + (N + 1)'(1);
                    phase <= (phase == period_q - N'(1)) ? '0 : phase + N'(1);
                    if (last || et_stop) begin
                        z_valid <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    z_valid <= 1'b0;
                    done    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sng_et_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sng_et_ctrl
// Self-checking bench for sng_et_ctrl (W = N = 8). A behavioural model of a
// run predicts every output each cycle; full-length runs are also checked
// against closed-form counts of ones and rshift pulses.
// ----------------------------------------------------------------------------
module tb_sng_et_ctrl;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  x;
    logic [N-1:0]  seed;
    logic [LW-1:0] len_log2;
    logic [N-1:0]  shift_period;
    logic          et_stop;
    logic          busy;
    logic          z_valid;
    logic          Z;
    logic          rshift;
    logic          done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sng_et_ctrl #(.W(W), .N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .x            (x),
        .seed         (seed),
        .len_log2     (len_log2),
        .shift_period (shift_period),
        .et_stop      (et_stop),
        .busy         (busy),
        .z_valid      (z_valid),
        .Z            (Z),
        .rshift       (rshift),
        .done         (done)
    );

    // Reference sequence: polynomial x^8 + x^6 + x^5 + x^4 + 1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Over a full 256-cycle run every non-zero value appears once and the
    // seed appears a second time, so the count of ones is closed-form.
    function automatic int full_run_ones(input int xv, input int sv);
        int s;
        s = (sv == 0) ? 1 : sv;
        return ((xv == 0) ? 0 : xv - 1) + ((s < xv) ? 1 : 0);
    endfunction

    // One complete run, predicted cycle by cycle; ends inside the IDLE cycle
    // that follows DONE, after its negedge.
    task automatic test_one_run(input string tag, input int rx, input int rseed,
                                input int rlen, input int rper, input int et_at,
                                input bit hold, output int ones, output int shifts);
        int         len_eff;
        int         last_k;
        logic [7:0] m;
        logic [4:0] exp_v;
        logic [4:0] act_v;
        logic       ze;
        logic       re;
        len_eff = (rlen > N) ? N : rlen;
        last_k  = (et_at >= 1 && et_at <= (1 << len_eff)) ? et_at : (1 << len_eff);
        m       = (rseed == 0) ? 8'd1 : 8'(rseed);
        ones    = 0;
        shifts  = 0;
        x            = 8'(rx);
        seed         = 8'(rseed);
        len_log2     = LW'(rlen);
        shift_period = 8'(rper);
        et_stop      = 1'b0;
        start        = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            et_stop = (k == et_at);
            #1;
            ze    = (int'(m) < rx);
            re    = (rper != 0) && (k % rper == 0) && (k != last_k);
            exp_v = {1'b1, 1'b1, ze, re, 1'b0};
            act_v = {busy, z_valid, Z, rshift, done};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL %s run cycle %0d: {busy,z_valid,Z,rshift,done} got %b expected %b",
                         tag, k, act_v, exp_v);
            end
            ones   += int'(Z === 1'b1);
            shifts += int'(rshift === 1'b1);
            m = lfsr_next(m);
        end
        @(negedge clk);
        et_stop = 1'b0;
        if (!hold) start = 1'b0;
        #1;
        vectors++;
        if ({busy, z_valid, Z, rshift, done} !== 5'b10001) begin
            miscompares++;
            $display("[TB] FAIL %s done cycle: got %b expected 10001", tag,
                     {busy, z_valid, Z, rshift, done});
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({busy, z_valid, Z, rshift, done} !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL %s idle cycle: got %b expected 00000", tag,
                     {busy, z_valid, Z, rshift, done});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; x = 8'hFF; seed = 8'h5A;
        len_log2 = 4'd3; shift_period = 8'd1; et_stop = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({busy, z_valid, Z, rshift, done} !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL reset outputs: got %b expected 00000",
                     {busy, z_valid, Z, rshift, done});
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_full_length();
        int ones, shifts, rx, rs;
        test_one_run("x128", 128, 1, 8, 0, 0, 1'b0, ones, shifts);
        vectors++;
        if (ones !== 128 || shifts !== 0) begin
            miscompares++;
            $display("[TB] FAIL x128 counts: ones %0d rshift %0d expected 128 and 0", ones, shifts);
        end
        test_one_run("x0", 0, 77, 8, 0, 0, 1'b0, ones, shifts);
        vectors++;
        if (ones !== 0) begin
            miscompares++;
            $display("[TB] FAIL x0 ones: got %0d expected 0", ones);
        end
        test_one_run("x255", 255, 1, 8, 0, 0, 1'b0, ones, shifts);
        vectors++;
        if (ones !== full_run_ones(255, 1)) begin
            miscompares++;
            $display("[TB] FAIL x255 ones: got %0d expected %0d", ones, full_run_ones(255, 1));
        end
        for (int i = 0; i < 3; i++) begin
            rx = int'($urandom_range(255, 0));
            rs = int'($urandom_range(255, 0));
            test_one_run("full_rand", rx, rs, 8, 0, 0, 1'b0, ones, shifts);
            vectors++;
            if (ones !== full_run_ones(rx, rs)) begin
                miscompares++;
                $display("[TB] FAIL full_rand x=%0d seed=%0d ones: got %0d expected %0d",
                         rx, rs, ones, full_run_ones(rx, rs));
            end
        end
    endtask

    task automatic test_rshift_period();
        int ones, shifts, rl, rp, expect_sh;
        test_one_run("len4_p4", 200, 9, 4, 4, 0, 1'b0, ones, shifts);
        vectors++;
        if (shifts !== 3) begin
            miscompares++;
            $display("[TB] FAIL len4_p4 rshift count: got %0d expected 3", shifts);
        end
        test_one_run("len0", 255, 3, 0, 1, 0, 1'b0, ones, shifts);
        for (int i = 0; i < 6; i++) begin
            rl = int'($urandom_range(8, 0));
            rp = int'($urandom_range(9, 0));
            expect_sh = (rp == 0) ? 0 : ((1 << rl) - 1) / rp;
            test_one_run("period_rand", int'($urandom_range(255, 0)),
                         int'($urandom_range(255, 0)), rl, rp, 0, 1'b0, ones, shifts);
            vectors++;
            if (shifts !== expect_sh) begin
                miscompares++;
                $display("[TB] FAIL period_rand len=%0d p=%0d rshift count: got %0d expected %0d",
                         rl, rp, shifts, expect_sh);
            end
        end
    endtask

    task automatic test_et_stop();
        int ones, shifts;
        test_one_run("et10", 90, 5, 8, 0, 10, 1'b0, ones, shifts);
        test_one_run("et_on_shift", 90, 5, 4, 2, 6, 1'b0, ones, shifts);
        vectors++;
        if (shifts !== 2) begin
            miscompares++;
            $display("[TB] FAIL et_on_shift rshift count: got %0d expected 2", shifts);
        end
        test_one_run("et_natural_last", 30, 11, 3, 2, 8, 1'b0, ones, shifts);
        for (int i = 0; i < 4; i++) begin
            test_one_run("et_rand", int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
                         int'($urandom_range(8, 1)), int'($urandom_range(5, 0)),
                         int'($urandom_range(40, 1)), 1'b0, ones, shifts);
        end
    endtask

    task automatic test_reset_midrun();
        int ones, shifts;
        x = 8'd200; seed = 8'd37; len_log2 = 4'd8; shift_period = 8'd3;
        et_stop = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        vectors++;
        if (z_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrun z_valid before reset: got %b expected 1", z_valid);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, z_valid, Z, rshift, done} !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL midrun reset outputs: got %b expected 00000",
                     {busy, z_valid, Z, rshift, done});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, z_valid, Z, rshift, done} !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL after reset (no done): got %b expected 00000",
                     {busy, z_valid, Z, rshift, done});
        end
        test_one_run("seed0", 100, 0, 8, 0, 0, 1'b0, ones, shifts);
        vectors++;
        if (ones !== full_run_ones(100, 1)) begin
            miscompares++;
            $display("[TB] FAIL seed0 ones: got %0d expected %0d", ones, full_run_ones(100, 1));
        end
    endtask

    task automatic test_back_to_back();
        int ones, shifts;
        for (int i = 0; i < 3; i++) begin
            test_one_run("b2b", int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
                         2, 1, 0, 1'b1, ones, shifts);
        end
        start = 1'b0;
    endtask

    task automatic test_len_clamp();
        int ones, shifts;
        test_one_run("clamp15", 64, 200, 15, 0, 0, 1'b0, ones, shifts);
        vectors++;
        if (ones !== full_run_ones(64, 200)) begin
            miscompares++;
            $display("[TB] FAIL clamp15 ones: got %0d expected %0d", ones, full_run_ones(64, 200));
        end
    endtask

    initial begin
        test_reset();
        test_full_length();
        test_rshift_period();
        test_et_stop();
        test_reset_midrun();
        test_back_to_back();
        test_len_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
